// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between instruction fetch and load/store
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   if_req_i/if_addr_i/if_flush_i    fetch request, address and kill
//   if_rsp_valid_o/if_rsp_data_o     fetch response pulse and data
//   dm_req_i/dm_addr_i/dm_wr_i/dm_wr_data_i   load/store request
//   dm_rsp_valid_o/dm_rsp_data_o     load/store response pulse and data (0 for stores)
//   mem_req_o/mem_addr_o/mem_wr_o/mem_wr_data_o/mem_ready_i   memory request handshake
//   mem_rvalid_i/mem_rd_data_i       memory completion and read data
//   busy_o                           a transaction is in flight
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_rsp_valid_o,
    output logic [63:0] if_rsp_data_o,
    input  logic        dm_req_i,
    input  logic [63:0] dm_addr_i,
    input  logic        dm_wr_i,
    input  logic [63:0] dm_wr_data_i,
    output logic        dm_rsp_valid_o,
    output logic [63:0] dm_rsp_data_o,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [63:0] mem_wr_data_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rd_data_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t      state_q;
    logic        owner_if_q;
    logic [63:0] addr_q;
    logic        wr_q;
    logic [63:0] wr_data_q;
    logic [3:0]  starve_q;
    logic        discard_q;
    logic        mem_req_q;
    logic        if_rsp_valid_q;
    logic [63:0] if_rsp_data_q;
    logic        dm_rsp_valid_q;
    logic [63:0] dm_rsp_data_q;
    logic        if_valid;
    logic        grant_if;
    logic        flush_own;
    assign if_valid  = if_req_i & ~if_flush_i;
    assign grant_if  = if_valid & (~dm_req_i | (starve_q >= 4'(STARVE_LIMIT)));
    assign flush_own = owner_if_q & if_flush_i;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            owner_if_q     <= 1'b0;
            addr_q         <= '0;
            wr_q           <= 1'b0;
            wr_data_q      <= '0;
            starve_q       <= '0;
            discard_q      <= 1'b0;
            mem_req_q      <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            dm_rsp_valid_q <= 1'b0;
            dm_rsp_data_q  <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (if_valid | dm_req_i) begin
                    state_q    <= ISSUE;
                    mem_req_q  <= 1'b1;
                    owner_if_q <= grant_if;
                    addr_q     <= grant_if ? if_addr_i : dm_addr_i;
                    wr_q       <= ~grant_if & dm_wr_i;
                    wr_data_q  <= grant_if ? '0 : dm_wr_data_i;
                    discard_q  <= 1'b0;
                    // fetch lost this arbitration only if it was asking and dm won
                    starve_q   <= grant_if ? 4'd0 :
                                  (if_req_i && starve_q != 4'hF) ? starve_q + 4'd1 : starve_q;
                end
                ISSUE: if (mem_ready_i) begin
                    // a flush coinciding with acceptance is treated as post-acceptance
                    state_q   <= WAIT;
                    mem_req_q <= 1'b0;
                    discard_q <= flush_own;
                end else if (flush_own) begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
                WAIT: begin
                    if (flush_own) discard_q <= 1'b1;
                    if (mem_rvalid_i) begin
                        state_q   <= IDLE;
                        discard_q <= 1'b0;
                        if (owner_if_q) begin
                            if (!(discard_q | if_flush_i)) begin
                                if_rsp_valid_q <= 1'b1;
                                if_rsp_data_q  <= mem_rd_data_i;
                            end
                        end else begin
                            dm_rsp_valid_q <= 1'b1;
                            dm_rsp_data_q  <= wr_q ? 64'h0 : mem_rd_data_i;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_req_o      = mem_req_q;
    assign mem_addr_o     = addr_q;
    assign mem_wr_o       = wr_q;
    assign mem_wr_data_o  = wr_data_q;
    assign if_rsp_valid_o = if_rsp_valid_q;
    assign if_rsp_data_o  = if_rsp_data_q;
    assign dm_rsp_valid_o = dm_rsp_valid_q;
    assign dm_rsp_data_o  = dm_rsp_data_q;
    assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req_i, if_flush_i, dm_req_i, dm_wr_i, mem_ready_i, mem_rvalid_i;
    logic [63:0] if_addr_i, dm_addr_i, dm_wr_data_i, mem_rd_data_i;
    logic        if_rsp_valid_o, dm_rsp_valid_o, mem_req_o, mem_wr_o, busy_o;
    logic [63:0] if_rsp_data_o, dm_rsp_data_o, mem_addr_o, mem_wr_data_o;
    int          total = 0;
    int          bad = 0;
    always #5 clk = ~clk;
    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
        .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_wr_i(dm_wr_i), .dm_wr_data_i(dm_wr_data_i),
        .dm_rsp_valid_o(dm_rsp_valid_o), .dm_rsp_data_o(dm_rsp_data_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i), .busy_o(busy_o)
    );
    typedef struct {
        logic        ifr, ifl, dmr, dmw, rdy, rv;
        logic [63:0] rd;
        logic        mreq, busy, ifv, dmv, wr;
        logic [63:0] addr, dmd, ifd;
    } vec_t;
    vec_t tbl[16];
    function automatic vec_t v(logic ifr, logic ifl, logic dmr, logic dmw, logic rdy, logic rv,
                               logic [63:0] rd, logic mreq, logic busy, logic ifv, logic dmv,
                               logic wr, logic [63:0] addr, logic [63:0] dmd, logic [63:0] ifd);
        vec_t r;
        r.ifr = ifr; r.ifl = ifl; r.dmr = dmr; r.dmw = dmw; r.rdy = rdy; r.rv = rv; r.rd = rd;
        r.mreq = mreq; r.busy = busy; r.ifv = ifv; r.dmv = dmv; r.wr = wr;
        r.addr = addr; r.dmd = dmd; r.ifd = ifd;
        return r;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        if_req_i = 0; if_flush_i = 0; dm_req_i = 0; dm_wr_i = 0;
        mem_ready_i = 0; mem_rvalid_i = 0; mem_rd_data_i = 0;
    endtask
    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"}, 64'(mem_req_o), 0);
        chk({tag, " busy"}, 64'(busy_o), 0);
        chk({tag, " if_rsp_valid"}, 64'(if_rsp_valid_o), 0);
        chk({tag, " dm_rsp_valid"}, 64'(dm_rsp_valid_o), 0);
        chk({tag, " if_rsp_data"}, if_rsp_data_o, 0);
        chk({tag, " dm_rsp_data"}, dm_rsp_data_o, 0);
        chk({tag, " mem_addr"}, mem_addr_o, 0);
        chk({tag, " mem_wr"}, 64'(mem_wr_o), 0);
        chk({tag, " mem_wr_data"}, mem_wr_data_o, 0);
    endtask
    initial begin
        if_addr_i = 64'h200; dm_addr_i = 64'h100; dm_wr_data_i = 64'h1234;
        // single load, delayed store, then a fetch that must see mem_wr forced to 0
        tbl[0]  = v(0,0,1,0,0,0,0,              1,1,0,0,0, 64'h100, 0, 0);
        tbl[1]  = v(0,0,1,0,1,0,0,              0,1,0,0,0, 64'h100, 0, 0);
        tbl[2]  = v(0,0,1,0,0,1,64'hDEADBEEF,   0,0,0,1,0, 64'h100, 64'hDEADBEEF, 0);
        tbl[3]  = v(0,0,0,0,0,0,0,              0,0,0,0,0, 64'h100, 64'hDEADBEEF, 0);
        tbl[4]  = v(0,0,1,1,0,0,0,              1,1,0,0,1, 64'h100, 64'hDEADBEEF, 0);
        tbl[5]  = v(0,0,1,1,0,0,0,              1,1,0,0,1, 64'h100, 64'hDEADBEEF, 0);
        tbl[6]  = v(0,0,1,1,0,0,0,              1,1,0,0,1, 64'h100, 64'hDEADBEEF, 0);
        tbl[7]  = v(0,0,1,1,1,0,0,              0,1,0,0,1, 64'h100, 64'hDEADBEEF, 0);
        tbl[8]  = v(0,0,1,1,0,0,0,              0,1,0,0,1, 64'h100, 64'hDEADBEEF, 0);
        tbl[9]  = v(0,0,1,1,0,0,0,              0,1,0,0,1, 64'h100, 64'hDEADBEEF, 0);
        tbl[10] = v(0,0,1,1,0,1,64'hFFFF,       0,0,0,1,1, 64'h100, 0, 0);
        tbl[11] = v(0,0,0,0,0,0,0,              0,0,0,0,0, 64'h100, 0, 0);
        tbl[12] = v(1,0,0,1,0,0,0,              1,1,0,0,0, 64'h200, 0, 0);
        tbl[13] = v(1,0,0,0,1,0,0,              0,1,0,0,0, 64'h200, 0, 0);
        tbl[14] = v(1,0,0,0,0,1,64'hCAFE,       0,0,1,0,0, 64'h200, 0, 64'hCAFE);
        tbl[15] = v(0,0,0,0,0,0,0,              0,0,0,0,0, 64'h200, 0, 64'hCAFE);
        do_reset();
        chk_all_zero("reset");
        for (int i = 0; i < 16; i++) begin
            if_req_i = tbl[i].ifr; if_flush_i = tbl[i].ifl; dm_req_i = tbl[i].dmr;
            dm_wr_i = tbl[i].dmw; mem_ready_i = tbl[i].rdy; mem_rvalid_i = tbl[i].rv;
            mem_rd_data_i = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d mem_req", i), 64'(mem_req_o), 64'(tbl[i].mreq));
            chk($sformatf("vec%0d busy", i), 64'(busy_o), 64'(tbl[i].busy));
            chk($sformatf("vec%0d if_rsp_valid", i), 64'(if_rsp_valid_o), 64'(tbl[i].ifv));
            chk($sformatf("vec%0d dm_rsp_valid", i), 64'(dm_rsp_valid_o), 64'(tbl[i].dmv));
            chk($sformatf("vec%0d dm_rsp_data", i), dm_rsp_data_o, tbl[i].dmd);
            chk($sformatf("vec%0d if_rsp_data", i), if_rsp_data_o, tbl[i].ifd);
            if (tbl[i].mreq) begin
                chk($sformatf("vec%0d mem_wr", i), 64'(mem_wr_o), 64'(tbl[i].wr));
                chk($sformatf("vec%0d mem_addr", i), mem_addr_o, tbl[i].addr);
                if (tbl[i].wr) chk($sformatf("vec%0d mem_wr_data", i), mem_wr_data_o, 64'h1234);
            end
        end
        // contention: both requesters held, zero-wait memory, fetch wins every 5th grant
        do_reset();
        if_addr_i = 64'h1000; dm_addr_i = 64'h2000;
        if_req_i = 1; dm_req_i = 1; mem_ready_i = 1; mem_rvalid_i = 1; mem_rd_data_i = 64'h55;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk($sformatf("grant%0d mem_req", g), 64'(mem_req_o), 1);
            chk($sformatf("grant%0d addr", g), mem_addr_o, (g % 5 == 4) ? 64'h1000 : 64'h2000);
            tick();
            tick();
            chk($sformatf("grant%0d if_rsp", g), 64'(if_rsp_valid_o), 64'(g % 5 == 4));
            chk($sformatf("grant%0d dm_rsp", g), 64'(dm_rsp_valid_o), 64'(g % 5 != 4));
        end
        // flush while fetch waits for completion, with a dm request pending
        do_reset();
        if_addr_i = 64'h200; dm_addr_i = 64'h100;
        if_req_i = 1; mem_ready_i = 1;
        tick();
        chk("wflush issue addr", mem_addr_o, 64'h200);
        dm_req_i = 1;
        tick();
        if_req_i = 0; if_flush_i = 1; mem_ready_i = 0;
        tick();
        if_flush_i = 0; mem_rvalid_i = 1; mem_rd_data_i = 64'hBAD;
        tick();
        chk("wflush if_rsp", 64'(if_rsp_valid_o), 0);
        chk("wflush if_data", if_rsp_data_o, 0);
        chk("wflush busy", 64'(busy_o), 0);
        mem_rvalid_i = 0;
        tick();
        chk("wflush dm grant req", 64'(mem_req_o), 1);
        chk("wflush dm grant addr", mem_addr_o, 64'h100);
        mem_ready_i = 1;
        tick();
        mem_ready_i = 0; mem_rvalid_i = 1; mem_rd_data_i = 64'h77;
        tick();
        chk("wflush dm rsp", 64'(dm_rsp_valid_o), 1);
        chk("wflush dm data", dm_rsp_data_o, 64'h77);
        // flush during ISSUE before acceptance
        do_reset();
        if_req_i = 1;
        tick();
        chk("iflush issue", 64'(mem_req_o), 1);
        if_req_i = 0; if_flush_i = 1;
        tick();
        chk("iflush mem_req", 64'(mem_req_o), 0);
        chk("iflush busy", 64'(busy_o), 0);
        if_flush_i = 0;
        tick();
        chk("iflush if_rsp", 64'(if_rsp_valid_o), 0);
        chk("iflush dm_rsp", 64'(dm_rsp_valid_o), 0);
        // reset while a load waits for completion
        do_reset();
        dm_req_i = 1; mem_ready_i = 1;
        tick();
        tick();
        chk("rstwait busy", 64'(busy_o), 1);
        resetn = 0; dm_req_i = 0; mem_ready_i = 0;
        tick();
        chk_all_zero("rstwait");
        resetn = 1; mem_rvalid_i = 1; mem_rd_data_i = 64'h99;
        tick();
        tick();
        chk("rstwait late dm_rsp", 64'(dm_rsp_valid_o), 0);
        chk("rstwait late if_rsp", 64'(if_rsp_valid_o), 0);
        chk("rstwait late busy", 64'(busy_o), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port between the instruction-fetch requester and the load/store (memory stage) requester. It runs one transaction at a time through a registered issue/wait state machine. It gives the data side priority and uses a starvation counter so fetch cannot be locked out. Read data and write acknowledges are routed back to whichever requester owns the transaction. It sits between the core's fetch/memory stages and the data memory model (later, the AXI bridge).

## Interface
Parameters:
- STARVE_LIMIT, default 4: number of consecutive cycles fetch may lose arbitration before it is forced to win. Legal range is 1-15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- if_req_i  in  1  fetch request; held until if_rsp_valid_o or if_flush_i.
- if_addr_i  in  64  fetch address, 8-byte aligned.
- if_flush_i  in  1  kills the outstanding or pending fetch transaction.
- if_rsp_valid_o  out  1  one-cycle pulse; fetch data is valid.
- if_rsp_data_o  out  64  fetch read data.
- dm_req_i  in  1  load/store request; held until dm_rsp_valid_o.
- dm_addr_i  in  64  row address.
- dm_wr_i  in  1  1 = store, 0 = load.
- dm_wr_data_i  in  64  store data.
- dm_rsp_valid_o  out  1  one-cycle pulse; load data is valid or the store has completed.
- dm_rsp_data_o  out  64  load read data; 0 for stores.
- mem_req_o  out  1  request to memory; held until mem_ready_i.
- mem_addr_o  out  64  latched address.
- mem_wr_o  out  1  latched write flag.
- mem_wr_data_o  out  64  latched store data.
- mem_ready_i  in  1  memory accepts the request this cycle.
- mem_rvalid_i  in  1  memory completion; read data is valid or the write has completed.
- mem_rd_data_i  in  64  memory read data.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- States are IDLE, ISSUE and WAIT.
- IDLE:
  - If any request is present (an if_req_i with if_flush_i asserted does not count), arbitrate, then latch owner, addr, wr and wr_data into registers and go to ISSUE.
  - If no request is present, stay in IDLE.
- Arbitration:
  - When only one requester is asking, it wins.
  - When both are asking, dm wins, unless starve_cnt >= STARVE_LIMIT, in which case fetch wins.
  - A fetch grant always forces mem_wr to 0.
- Starvation counter:
  - starve_cnt is 4 bits wide and saturates at 15.
  - It increments on each IDLE cycle in which if_req_i=1 and dm wins.
  - It clears on a fetch grant and on reset.
  - It holds in all other cycles.
- ISSUE:
  - mem_req_o=1, and mem_addr/wr/wr_data are driven from the latched registers.
  - If mem_ready_i=1, go to WAIT.
  - If owner is fetch and if_flush_i=1 before acceptance, drop mem_req_o and return to IDLE next cycle with no response. A flush in the same cycle as mem_ready_i=1 counts as after acceptance (see WAIT).
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i=1, register the response to the owner and return to IDLE.
  - If owner is fetch and if_flush_i is seen at any point in ISSUE-accept or WAIT, set a discard flag. At completion, if_rsp_valid_o stays 0; the memory transaction still completes.
- Response data: dm_rsp_data_o is mem_rd_data_i for loads and 64'h0 for stores. if_rsp_data_o is mem_rd_data_i. Both hold their value between pulses.
- A mem_rvalid_i outside WAIT is ignored.
- A requester that drops req after grant still receives its response pulse, except for a flushed fetch.
- Reset mid-transaction returns the block to IDLE and drops any in-flight response. The memory model is reset by the same resetn.

## Timing
- Reset values: every output is 0; state=IDLE; starve_cnt=0; discard=0; all latched registers are 0.
- All outputs are registered, with no combinational path from an input to an output.
- Minimum latency, from cycle 0 (request sampled in IDLE):
  - cycle 1: ISSUE, mem_req_o=1; mem_ready_i=1.
  - cycle 2: WAIT; mem_rvalid_i=1.
  - cycle 3: rsp_valid_o pulse and state=IDLE, so a new arbitration is sampled in cycle 3.
- Back-to-back throughput is one transaction per 3 cycles when memory responds with zero wait states.
- Each cycle of mem_ready_i=0 in ISSUE and each cycle of mem_rvalid_i=0 in WAIT adds one cycle of latency.
- The rsp_valid pulses are exactly 1 cycle wide. At most one of if_rsp_valid_o and dm_rsp_valid_o is high in any cycle.
- Address, wr and wr_data must stay stable on mem_* while mem_req_o=1.

## Test plan
- Single load: dm_req with addr=0x100, mem_rd_data_i=0xDEAD_BEEF, zero wait states -> mem_req_o in cycle 1; dm_rsp_valid_o in cycle 3 with data 0xDEADBEEF; if_rsp_valid_o stays 0.
- Contention: if_req and dm_req held continuously, STARVE_LIMIT=4, zero-wait memory -> grant sequence dm, dm, dm, dm, if, dm, …; starve_cnt clears after the fetch grant.
- Store ack: dm_wr_i=1, data 0x1234, mem_ready_i delayed 2 cycles and mem_rvalid_i delayed 3 cycles -> mem_wr_o=1 and mem_wr_data_o=0x1234 stable throughout ISSUE; dm_rsp_valid_o 1 cycle after rvalid with data 0.
- Flush: fetch owns the transaction in WAIT and if_flush_i pulses -> rvalid completes; no if_rsp_valid_o; next cycle in IDLE, a pending dm_req is granted.
- Flush in ISSUE with mem_ready_i=0 -> mem_req_o drops the next cycle; state=IDLE; no response pulse.
- Reset in WAIT: resetn=0 for 1 cycle -> all outputs 0, busy_o=0, and a later mem_rvalid_i produces no response.
